nibble_serial_adder_3op: RTL and testbench

//  Sequential three-operand adder for wide operands: in1 + in2 + in3 + cin.

---
 rtl/nsa_pkg.sv | 14 +
 rtl/nibble_add_3op.sv | 24 ++
 rtl/nibble_serial_adder_3op.sv | 116 +++++++++++
 tb/tb_nibble_serial_adder_3op.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nsa_pkg.sv
// Shared types and widths for the nibble-serial three-operand adder.
// State encoding and slice/carry widths live here.
package nsa_pkg;

    localparam int NIB_W   = 4;
    localparam int CARRY_W = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/nibble_add_3op.sv
// One 4-bit slice of a three-operand add with a 0..2 carry-in.
// Worst case 15+15+15+2 = 47, so the carry-out fits in 2 bits.
module nibble_add_3op
    import nsa_pkg::*;
(
    input  logic [NIB_W-1:0]   a,
    input  logic [NIB_W-1:0]   b,
    input  logic [NIB_W-1:0]   c,
    input  logic [CARRY_W-1:0] ci,
    output logic [NIB_W-1:0]   s,
    output logic [CARRY_W-1:0] co
);

    logic [NIB_W+CARRY_W-1:0] total;

    // Widen every term before adding so nothing is lost
    always_comb begin
        total = {2'b00, a} + {2'b00, b} + {2'b00, c}
              + {4'b0000, ci};
        s     = total[NIB_W-1:0];
        co    = total[NIB_W+CARRY_W-1:NIB_W];
    end

endmodule

// File: rtl/nibble_serial_adder_3op.sv
// Sequential in1+in2+in3+cin, one nibble per clock, LSB first.
// Result is held in DONE until the consumer takes it.
module nibble_serial_adder_3op
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    input  logic [WIDTH-1:0] in3,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic [1:0]       cout
);

    localparam int NNIB  = WIDTH / NIB_W;
    localparam int CNT_W = (NNIB > 1) ? $clog2(NNIB) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NNIB - 1);

    if (WIDTH % NIB_W != 0 || WIDTH < NIB_W) begin : g_bad_width
        $error("WIDTH must be a multiple of 4 and >= 4");
    end

    state_t state;
    state_t state_nxt;

    logic [WIDTH-1:0]   a_q;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH-1:0]   c_q;
    logic [WIDTH-1:0]   sum_q;
    logic [WIDTH-1:0]   sum_shift;
    logic [CARRY_W-1:0] carry_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [NIB_W-1:0]   nib_s;
    logic [CARRY_W-1:0] nib_co;
    logic               accept;

    nibble_add_3op u_nib (
        .a  (a_q[NIB_W-1:0]),
        .b  (b_q[NIB_W-1:0]),
        .c  (c_q[NIB_W-1:0]),
        .ci (carry_q),
        .s  (nib_s),
        .co (nib_co)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // Next state and handshake outputs; no in_valid->in_ready path
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        unique case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = ST_RUN;
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                in_ready  = out_ready;
                if (out_ready)
                    state_nxt = in_valid ? ST_RUN : ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign accept = in_valid & in_ready;

    // New slice enters at the top of the sum register
    assign sum_shift = (sum_q >> NIB_W)
                     | (WIDTH'(nib_s) << (WIDTH - NIB_W));

    // Operand capture, slice stepping and result accumulation
    always_ff @(posedge clk) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            c_q     <= '0;
            sum_q   <= '0;
            carry_q <= '0;
            cnt_q   <= '0;
        end else if (accept) begin
            a_q     <= in1;
            b_q     <= in2;
            c_q     <= in3;
            carry_q <= {1'b0, cin};
            cnt_q   <= '0;
        end else if (state == ST_RUN) begin
            a_q     <= a_q >> NIB_W;
            b_q     <= b_q >> NIB_W;
            c_q     <= c_q >> NIB_W;
            sum_q   <= sum_shift;
            carry_q <= nib_co;
            cnt_q   <= cnt_q + CNT_W'(1);
        end
    end

    assign sum  = sum_q;
    assign cout = carry_q;

endmodule

// File: tb/tb_nibble_serial_adder_3op.sv
// Directed checks on a 16-bit adder plus randomised
// stall traffic on 4-bit and 32-bit instances.
module tb_nibble_serial_adder_3op;

    localparam int NR = 2000;

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] in1 = '0;
    logic [15:0] in2 = '0;
    logic [15:0] in3 = '0;
    logic        cin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] sum;
    logic [1:0]  cout;

    logic       r4_iv = 1'b0;
    logic       r4_ir;
    logic [3:0] r4_a = '0;
    logic [3:0] r4_b = '0;
    logic [3:0] r4_c = '0;
    logic       r4_ci = 1'b0;
    logic       r4_ov;
    logic       r4_or = 1'b0;
    logic [3:0] r4_sum;
    logic [1:0] r4_cout;

    logic        r32_iv = 1'b0;
    logic        r32_ir;
    logic [31:0] r32_a = '0;
    logic [31:0] r32_b = '0;
    logic [31:0] r32_c = '0;
    logic        r32_ci = 1'b0;
    logic        r32_ov;
    logic        r32_or = 1'b0;
    logic [31:0] r32_sum;
    logic [1:0]  r32_cout;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    nibble_serial_adder_3op #(.WIDTH(16)) u_dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in1(in1), .in2(in2), .in3(in3), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .sum(sum), .cout(cout)
    );

    nibble_serial_adder_3op #(.WIDTH(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(r4_iv), .in_ready(r4_ir),
        .in1(r4_a), .in2(r4_b), .in3(r4_c), .cin(r4_ci),
        .out_valid(r4_ov), .out_ready(r4_or),
        .sum(r4_sum), .cout(r4_cout)
    );

    nibble_serial_adder_3op #(.WIDTH(32)) u_dut32 (
        .clk(clk), .reset(reset),
        .in_valid(r32_iv), .in_ready(r32_ir),
        .in1(r32_a), .in2(r32_b), .in3(r32_c), .cin(r32_ci),
        .out_valid(r32_ov), .out_ready(r32_or),
        .sum(r32_sum), .cout(r32_cout)
    );

    task automatic chk(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h",
                     tag, got, exp);
        end
    endtask

    // One operation on the 16-bit DUT, with an optional
    // backpressure window in DONE before the result is taken
    task automatic run_one(input string tag,
                           input logic [15:0] a,
                           input logic [15:0] b,
                           input logic [15:0] c,
                           input logic ci,
                           input logic [15:0] es,
                           input logic [1:0] ec,
                           input int hold);
        int k;
        @(negedge clk);
        in1 = a; in2 = b; in3 = c; cin = ci;
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1 chk({tag, "_acc_rdy"}, in_ready, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in1 = '1; in2 = '1; in3 = '1; cin = 1'b1;
        k = 0;
        while (!out_valid && k < 20) begin
            @(posedge clk);
            #1 k++;
        end
        chk({tag, "_latency"}, k, 4);
        chk({tag, "_sum"}, sum, es);
        chk({tag, "_cout"}, cout, ec);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            in_valid = h[0];
            in1 = 16'($urandom);
            #1;
            chk({tag, "_bp_ov"}, out_valid, 1);
            chk({tag, "_bp_sum"}, sum, es);
            chk({tag, "_bp_cout"}, cout, ec);
            chk({tag, "_bp_rdy"}, in_ready, 0);
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk({tag, "_drain_ov"}, out_valid, 0);
        chk({tag, "_drain_rdy"}, in_ready, 1);
    endtask

    logic [15:0] bv1 [3];
    logic [15:0] bv2 [3];
    logic [15:0] bv3 [3];
    logic        bci [3];
    logic [17:0] bexp [3];

    task automatic back_to_back();
        int idx;
        int nres;
        int last;
        idx = 0; nres = 0; last = 0;
        out_ready = 1'b1;
        for (int cy = 0; cy < 40 && nres < 3; cy++) begin
            @(negedge clk);
            in_valid = (idx < 3);
            if (idx < 3) begin
                in1 = bv1[idx]; in2 = bv2[idx];
                in3 = bv3[idx]; cin = bci[idx];
            end
            #1;
            if (out_valid) begin
                chk("b2b_res", {cout, sum}, bexp[nres]);
                if (nres > 0) chk("b2b_gap", cy - last, 5);
                last = cy;
                nres++;
            end
            if (in_valid && in_ready) idx++;
        end
        chk("b2b_count", nres, 3);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1 chk("b2b_no_dup", out_valid, 0);
    endtask

    task automatic rand4();
        logic [5:0] q[$];
        logic [5:0] e;
        int got;
        int sent;
        logic pend;
        got = 0; sent = 0; pend = 1'b0;
        for (int cy = 0; cy < 60000 && got < NR; cy++) begin
            @(negedge clk);
            if (!pend && sent < NR) begin
                r4_a = 4'($urandom); r4_b = 4'($urandom);
                r4_c = 4'($urandom); r4_ci = 1'($urandom);
                pend = 1'b1;
            end
            r4_iv = pend && ($urandom_range(0, 3) != 0);
            r4_or = ($urandom_range(0, 3) != 0);
            #1;
            if (r4_ov && r4_or) begin
                if (q.size() == 0) chk("r4_extra", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("r4_res", {r4_cout, r4_sum}, e);
                end
                got++;
            end
            if (r4_iv && r4_ir) begin
                q.push_back(6'(r4_a) + 6'(r4_b)
                          + 6'(r4_c) + 6'(r4_ci));
                pend = 1'b0;
                sent++;
            end
        end
        @(posedge clk);
        #1;
        r4_iv = 1'b0;
        r4_or = 1'b0;
        chk("r4_count", got, NR);
        chk("r4_left", q.size(), 0);
    endtask

    task automatic rand32();
        logic [33:0] q[$];
        logic [33:0] e;
        int got;
        int sent;
        logic pend;
        got = 0; sent = 0; pend = 1'b0;
        for (int cy = 0; cy < 60000 && got < NR; cy++) begin
            @(negedge clk);
            if (!pend && sent < NR) begin
                r32_a = $urandom; r32_b = $urandom;
                r32_c = $urandom; r32_ci = 1'($urandom);
                pend = 1'b1;
            end
            r32_iv = pend && ($urandom_range(0, 3) != 0);
            r32_or = ($urandom_range(0, 3) != 0);
            #1;
            if (r32_ov && r32_or) begin
                if (q.size() == 0) chk("r32_extra", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("r32_res", {r32_cout, r32_sum}, e);
                end
                got++;
            end
            if (r32_iv && r32_ir) begin
                q.push_back(34'(r32_a) + 34'(r32_b)
                          + 34'(r32_c) + 34'(r32_ci));
                pend = 1'b0;
                sent++;
            end
        end
        @(posedge clk);
        #1;
        r32_iv = 1'b0;
        r32_or = 1'b0;
        chk("r32_count", got, NR);
        chk("r32_left", q.size(), 0);
    endtask

    // Main sequence
    initial begin
        bv1[0] = 16'h0001; bv2[0] = 16'h0002;
        bv3[0] = 16'h0003; bci[0] = 1'b0;
        bexp[0] = 18'h00006;
        bv1[1] = 16'h8000; bv2[1] = 16'h8000;
        bv3[1] = 16'h8000; bci[1] = 1'b1;
        bexp[1] = 18'h18001;
        bv1[2] = 16'hFFFF; bv2[2] = 16'h0001;
        bv3[2] = 16'h0000; bci[2] = 1'b0;
        bexp[2] = 18'h10000;

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_ov", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_rdy", in_ready, 1);

        run_one("max", 16'hFFFF, 16'hFFFF, 16'hFFFF, 1'b1,
                16'hFFFE, 2'b10, 5);
        run_one("mix", 16'h1234, 16'h4321, 16'h0F0F, 1'b0,
                16'h6464, 2'b00, 0);
        run_one("cin", 16'h0000, 16'h0000, 16'h0000, 1'b1,
                16'h0001, 2'b00, 0);

        back_to_back();

        @(negedge clk);
        in1 = 16'hAAAA; in2 = 16'h5555; in3 = 16'h1111;
        cin = 1'b1;
        in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        chk("mrst_ov", out_valid, 0);
        chk("mrst_rdy", in_ready, 1);
        @(negedge clk);
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1 chk("mrst_dropped", out_valid, 0);
        run_one("post", 16'h0001, 16'h0002, 16'h0003, 1'b1,
                16'h0007, 2'b00, 0);

        fork
            rand4();
            rand32();
        join

        $display("Result: errors=%0d of %0d checks",
                 n_err, n_chk);
        $finish;
    end

endmodule
